// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, response-state encoding and access-size constants for the
// single-port RAM arbiter and its lane-alignment helper.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        PEND_IDLE = 2'd0,
        PEND_INST = 2'd1,
        PEND_DRD  = 2'd2,
        PEND_DACK = 2'd3
    } pend_e;

    localparam logic [SEL_W-1:0] MEM_SEL_BYTE = 4'b0001;
    localparam logic [SEL_W-1:0] MEM_SEL_HALF = 4'b0011;
    localparam logic [SEL_W-1:0] MEM_SEL_WORD = 4'b1111;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF request, MEM request and RAM-side signals around the arbiter.
// The master modport is the pipeline/RAM environment, the slave modport the arbiter.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              flush;
    logic              inst_grant;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_we;
    logic [SEL_W-1:0]  data_sel;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_grant;
    logic              data_valid;
    logic [DATA_W-1:0] data_rdata;
    logic              misalign;

    logic              ram_en;
    logic [SEL_W-1:0]  ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              stall_req;

    modport master (
        output inst_req, inst_addr, flush,
        output data_req, data_we, data_sel, data_addr, data_wdata,
        output ram_rdata,
        input  inst_grant, inst_valid, inst_rdata,
        input  data_grant, data_valid, data_rdata, misalign,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  stall_req
    );

    modport slave (
        input  inst_req, inst_addr, flush,
        input  data_req, data_we, data_sel, data_addr, data_wdata,
        input  ram_rdata,
        output inst_grant, inst_valid, inst_rdata,
        output data_grant, data_valid, data_rdata, misalign,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output stall_req
    );

endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// Combinational byte-lane steering for sub-word stores: byte enables, replicated
// write data and a misalignment flag from access size and the low address bits.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    output logic [SEL_W-1:0]  we,
    output logic [DATA_W-1:0] lane_wdata,
    output logic              misaligned
);

    // Lane enables and replicated data per access size; unknown sizes are misaligned.
    always_comb begin
        we         = {SEL_W{1'b0}};
        lane_wdata = {DATA_W{1'b0}};
        misaligned = 1'b0;
        case (sel)
            MEM_SEL_BYTE: begin
                we         = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            MEM_SEL_HALF: begin
                if (addr_lo[0]) begin
                    misaligned = 1'b1;
                end else begin
                    we         = 4'b0011 << addr_lo;
                    lane_wdata = {2{wdata[15:0]}};
                end
            end
            MEM_SEL_WORD: begin
                if (addr_lo != 2'b00) begin
                    misaligned = 1'b1;
                end else begin
                    we         = 4'b1111;
                    lane_wdata = wdata;
                end
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single RAM port shared by instruction fetch and MEM loads/stores: MEM-first
// priority with a starvation override for IF, and a one-cycle response tracker.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    pend_e             pend_q, pend_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              inst_drop_q, inst_drop_d;
    logic              misalign_q, misalign_d;

    logic              starve_hit_s;
    logic              inst_grant_s, data_grant_s;
    logic [SEL_W-1:0]  lane_we_s;
    logic [DATA_W-1:0] lane_wdata_s;
    logic              misaligned_s;
    logic              ram_en_s;
    logic [SEL_W-1:0]  ram_we_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic              inst_valid_s, data_valid_s, misalign_s;
    logic [DATA_W-1:0] inst_rdata_s, data_rdata_s;

    mem_lane_align u_lane_align (
        .sel        (bus.data_sel),
        .addr_lo    (bus.data_addr[1:0]),
        .wdata      (bus.data_wdata),
        .we         (lane_we_s),
        .lane_wdata (lane_wdata_s),
        .misaligned (misaligned_s)
    );

    assign starve_hit_s = (starve_cnt_q == CNT_MAX);

    // Issue decision; nothing is granted while reset is held so no response is orphaned.
    always_comb begin
        inst_grant_s = 1'b0;
        data_grant_s = 1'b0;
        if (rst) begin
            inst_grant_s = 1'b0;
            data_grant_s = 1'b0;
        end else if (starve_hit_s && bus.inst_req) begin
            inst_grant_s = 1'b1;
        end else if (bus.data_req) begin
            data_grant_s = 1'b1;
        end else if (bus.inst_req) begin
            inst_grant_s = 1'b1;
        end else begin
            inst_grant_s = 1'b0;
            data_grant_s = 1'b0;
        end
    end

    // RAM port drive; a misaligned MEM access is granted but never strobes the RAM.
    always_comb begin
        ram_en_s    = 1'b0;
        ram_we_s    = {SEL_W{1'b0}};
        ram_addr_s  = {ADDR_W{1'b0}};
        ram_wdata_s = {DATA_W{1'b0}};
        if (data_grant_s) begin
            ram_en_s   = ~misaligned_s;
            ram_addr_s = word_addr(bus.data_addr);
            if (bus.data_we && !misaligned_s) begin
                ram_we_s    = lane_we_s;
                ram_wdata_s = lane_wdata_s;
            end else begin
                ram_we_s    = {SEL_W{1'b0}};
                ram_wdata_s = {DATA_W{1'b0}};
            end
        end else if (inst_grant_s) begin
            ram_en_s   = 1'b1;
            ram_addr_s = word_addr(bus.inst_addr);
        end else begin
            ram_en_s = 1'b0;
        end
    end

    // Next-state for the starvation counter and the response tracker.
    always_comb begin
        starve_cnt_d = {CNT_W{1'b0}};
        pend_d       = PEND_IDLE;
        inst_drop_d  = bus.flush;
        misalign_d   = data_grant_s & misaligned_s;
        if (bus.inst_req && !inst_grant_s) begin
            if (starve_hit_s) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end else begin
            starve_cnt_d = {CNT_W{1'b0}};
        end
        if (inst_grant_s) begin
            pend_d = PEND_INST;
        end else if (data_grant_s) begin
            if (misaligned_s || bus.data_we) begin
                pend_d = PEND_DACK;
            end else begin
                pend_d = PEND_DRD;
            end
        end else begin
            pend_d = PEND_IDLE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= PEND_IDLE;
            starve_cnt_q <= {CNT_W{1'b0}};
            inst_drop_q  <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            starve_cnt_q <= starve_cnt_d;
            inst_drop_q  <= inst_drop_d;
            misalign_q   <= misalign_d;
        end
    end

    // Response decode from the registered state; a flush in either cycle drops a fetch.
    always_comb begin
        inst_valid_s = !rst && (pend_q == PEND_INST) && !inst_drop_q && !bus.flush;
        data_valid_s = !rst && ((pend_q == PEND_DRD) || (pend_q == PEND_DACK));
        misalign_s   = !rst && misalign_q;
        if (inst_valid_s) begin
            inst_rdata_s = bus.ram_rdata;
        end else begin
            inst_rdata_s = {DATA_W{1'b0}};
        end
        if (!rst && (pend_q == PEND_DRD)) begin
            data_rdata_s = bus.ram_rdata;
        end else begin
            data_rdata_s = {DATA_W{1'b0}};
        end
    end

    assign bus.inst_grant = inst_grant_s;
    assign bus.data_grant = data_grant_s;
    assign bus.ram_en     = ram_en_s;
    assign bus.ram_we     = ram_we_s;
    assign bus.ram_addr   = ram_addr_s;
    assign bus.ram_wdata  = ram_wdata_s;
    assign bus.stall_req  = (bus.inst_req & ~inst_grant_s) | (bus.data_req & ~data_grant_s);
    assign bus.inst_valid = inst_valid_s;
    assign bus.inst_rdata = inst_rdata_s;
    assign bus.data_valid = data_valid_s;
    assign bus.data_rdata = data_rdata_s;
    assign bus.misalign   = misalign_s;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single synchronous RAM port between instruction fetch (IF) and the MEM stage's loads and stores, one access per cycle. MEM has priority, with an anti-starvation override for IF. Any requester that is not granted raises a pipeline stall. Read data comes back raw and word-aligned one cycle later; WB performs byte/half extraction and extension.

## Interface
- STARVE_LIMIT, 4: consecutive denied IF cycles after which IF wins over MEM. Must be ≥1.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- inst_req  in  1  IF read request.
- inst_addr  in  `ADDR_BUS  IF byte address.
- flush  in  1  discard any outstanding IF response.
- inst_grant  out  1  IF access issued this cycle.
- inst_valid  out  1  inst_rdata valid.
- inst_rdata  out  `DATA_BUS  fetched word.
- data_req  in  1  MEM access request.
- data_we  in  1  1 = store, 0 = load.
- data_sel  in  `MEM_SEL_BUS  0001 byte, 0011 half, 1111 word.
- data_addr  in  `ADDR_BUS  byte address.
- data_wdata  in  `DATA_BUS  store data, right-justified.
- data_grant  out  1  MEM access issued this cycle.
- data_valid  out  1  MEM access completed; load data valid.
- data_rdata  out  `DATA_BUS  raw RAM word; 0 for stores and misaligned accesses.
- misalign  out  1  one-cycle pulse when a granted MEM access is misaligned.
- ram_en  out  1  RAM access strobe.
- ram_we  out  4  byte write enables.
- ram_addr  out  `ADDR_BUS  word address, low two bits 0.
- ram_wdata  out  `DATA_BUS  lane-replicated store data.
- ram_rdata  in  `DATA_BUS  RAM read data, valid the cycle after a read strobe.
- stall_req  out  1  a requester is being held off.

## Operation
- **Issue is combinational each cycle.**
  - If starve_cnt == STARVE_LIMIT and inst_req is high, IF wins.
  - Otherwise, if data_req is high, MEM wins.
  - Otherwise, if inst_req is high, IF wins.
  - Otherwise no grant.
  - At most one grant per cycle.
- **starve_cnt register, range 0..STARVE_LIMIT.**
  - Increments, saturating, when inst_req is high and inst_grant is low.
  - Clears when inst_grant is high or inst_req is low.
- **Lane alignment**, by address a = addr[1:0]:
  - Byte: ram_we = 0001 << a; ram_wdata = 4 copies of the byte.
  - Half: legal only when a[0] == 0. ram_we = 0011 << a; ram_wdata = 2 copies of the halfword.
  - Word: legal only when a == 00. ram_we = 1111.
  - Any other data_sel is treated as misaligned.
- **Misaligned MEM access.**
  - Still granted, but ram_en is forced to 0, so there is no RAM side effect.
  - misalign pulses next cycle together with data_valid, and data_rdata = 0.
- **Loads:** ram_en = 1, ram_we = 0000.
- **IF reads:** ram_en = 1, ram_we = 0000.
- **Stores:** ram_en = 1, ram_we as computed above.
- **Response FSM (pend)**, updated on clk:
  - States: IDLE, INST_PEND, DATA_RD, DATA_ACK.
  - Next state: IF grant → INST_PEND. MEM load → DATA_RD. MEM store or misaligned → DATA_ACK. No grant → IDLE.
  - INST_PEND: inst_valid = 1 and inst_rdata = ram_rdata, unless flush was high in the issue cycle or is high now. In that case the response is dropped and inst_valid = 0.
  - DATA_RD: data_valid = 1, data_rdata = ram_rdata.
  - DATA_ACK: data_valid = 1, data_rdata = 0.
- stall_req = (inst_req & ~inst_grant) | (data_req & ~data_grant).

## Timing
- **Reset:** pend = IDLE and starve_cnt = 0. All registered outputs are 0: inst_valid, data_valid, misalign, inst_rdata, data_rdata.
- **Combinational outputs (grants, ram_*, stall_req):** 0 whenever no request is present.
- **Latency:** grant in cycle N, valid in cycle N+1. Back-to-back grants are allowed every cycle; the responses pipeline one behind.
- **Reset mid-operation:** an outstanding response is discarded. No valid follows a reset cycle.
- **Simultaneous data_req and inst_req with starve_cnt < LIMIT:** MEM wins and stall_req = 1.
- **Counter saturation:** the count holds at LIMIT until IF is granted, then clears.
- **Requesters** hold request and address stable until granted. The arbiter never grants a request that was dropped.

## Structure
- Shared header bus.v gains:
  - `PEND_BUS` (2 bits) and the PEND_IDLE / PEND_INST / PEND_DRD / PEND_DACK encodings.
  - `MEM_SEL_BYTE`, `MEM_SEL_HALF`, `MEM_SEL_WORD` constants.
- Sub-module mem_lane_align: a combinational block computing ram_we, ram_wdata, and the misaligned flag from sel, addr[1:0] and wdata. It is reusable by a future cache.
- The arbiter proper contains the priority logic, starve_cnt and the pend FSM.

## Test plan
- **Load vs. fetch conflict:** data_req load at 0x104 and inst_req at 0x200 in the same cycle → data_grant = 1, stall_req = 1, ram_addr = 0x104. Next cycle: data_valid = 1 with the RAM word, and inst is granted.
- **Starvation override:** data_req held for 6 cycles with inst_req held, STARVE_LIMIT = 4 → inst_grant in the 5th cycle, then MEM resumes.
- **Byte store:** sel = 0001, addr = 0x13, wdata = 0xAB → ram_we = 1000, ram_wdata = 0xABABABAB. data_valid is pulsed next cycle with data_rdata = 0.
- **Misaligned word:** word load at 0x102 → ram_en = 0. Next cycle: misalign = 1, data_valid = 1, data_rdata = 0.
- **Flush:** inst granted at 0x40, flush high in the following cycle → inst_valid stays 0.
- **Reset mid-read:** rst asserted the cycle after a data grant → data_valid = 0, pend = IDLE, starve_cnt = 0.
